// File: rtl/mysystem_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package mysystem_sysid_pkg;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int unsigned SYSID_CNT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StWaitId,
    StRdTs,
    StWaitTs,
    StDone
  } sysid_state_e;

endpackage

// File: rtl/mysystem_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the system-ID slave.
interface mysystem_sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/mysystem_sysid_checker.sv
// Reads system ID and build timestamp from the sysid slave and compares them with the
// expected build values; reports pass/fail, per-field result and slave timeout.
module mysystem_sysid_checker
  import mysystem_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1591407027,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            start,
  mysystem_sysid_checker_if.master        avm,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            id_ok,
  output logic                            ts_ok,
  output logic                            timeout,
  output logic [31:0]                     id_value,
  output logic [31:0]                     ts_value
);

  // Limit is compared against the pre-increment count, so a phase lasts at most
  // TIMEOUT_CYCLES cycles.
  localparam logic [SYSID_CNT_W-1:0] CntLimit = SYSID_CNT_W'(TIMEOUT_CYCLES - 1);

  sysid_state_e           state_q, state_d;
  logic [SYSID_CNT_W-1:0] cnt_q, cnt_d;
  logic                   read_q, read_d;
  logic                   addr_q, addr_d;
  logic                   id_ok_q, id_ok_d;
  logic                   ts_ok_q, ts_ok_d;
  logic                   timeout_q, timeout_d;
  logic [31:0]            id_value_q, id_value_d;
  logic [31:0]            ts_value_q, ts_value_d;
  logic                   limit;

  always_comb begin
    state_d    = state_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    limit      = (cnt_q == CntLimit);

    // Handshake checks come first so they win over a coincident limit.
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRdId;
      end
      StRdId: begin
        if (!avm.avm_waitrequest) begin
          state_d = StWaitId;
        end else if (limit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StWaitId: begin
        if (avm.avm_readdatavalid) begin
          id_value_d = avm.avm_readdata;
          id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
          state_d    = StRdTs;
        end else if (limit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StRdTs: begin
        if (!avm.avm_waitrequest) begin
          state_d = StWaitTs;
        end else if (limit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StWaitTs: begin
        if (avm.avm_readdatavalid) begin
          ts_value_d = avm.avm_readdata;
          ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
          state_d    = StDone;
        end else if (limit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (start) begin
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
          state_d    = StRdId;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_d != state_q) || !busy) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Bus outputs are registered from the next state so they are stable under waitrequest.
    read_d = (state_d == StRdId) || (state_d == StRdTs);
    addr_d = (state_d == StRdTs) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;

  assign busy     = (state_q == StRdId) || (state_q == StWaitId) ||
                    (state_q == StRdTs) || (state_q == StWaitTs);
  assign done     = (state_q == StDone);
  assign pass     = done & id_ok_q & ts_ok_q & ~timeout_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_mysystem_sysid_checker.sv
// Self-checking bench for mysystem_sysid_checker: scripted sysid slave, vector table,
// hand-written corner sequences and randomized runs against a phase-length model.
module tb_mysystem_sysid_checker;

  localparam int unsigned T      = 8;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1591407027;

  typedef struct {
    int unsigned wait_id, lat_id, wait_ts, lat_ts;
    bit          resp_id, resp_ts;
    logic [31:0] data_id, data_ts;
    int unsigned edges;
    bit          pass, id_ok, ts_ok, tmo;
    logic [31:0] id_val, ts_val;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int checks = 0;
  int errors = 0;

  // Slave behaviour, per word address.
  int unsigned cfg_wait [2];
  int unsigned cfg_lat  [2];
  bit          cfg_resp [2];
  logic [31:0] cfg_data [2];
  bit          stray_rdv = 1'b0;

  mysystem_sysid_checker_if avm ();

  mysystem_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (T)
  ) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .avm      (avm.master),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scripted slave: stalls each read for cfg_wait cycles, answers cfg_lat cycles later.
  initial begin
    int unsigned hold, resp_cnt;
    bit          resp_pend;
    logic        resp_addr, hold_addr;
    hold = 0; resp_cnt = 0; resp_pend = 0; resp_addr = 0; hold_addr = 0;
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    avm.avm_readdata      = '0;
    forever begin
      @(negedge clock);
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata      = $urandom;
      if (!reset_n) begin
        resp_pend           = 0;
        hold                = 0;
        avm.avm_waitrequest = 1'b0;
      end else begin
        if (resp_pend) begin
          if (resp_cnt <= 1) begin
            resp_pend = 0;
            if (cfg_resp[resp_addr]) begin
              avm.avm_readdatavalid = 1'b1;
              avm.avm_readdata      = cfg_data[resp_addr];
            end
          end else begin
            resp_cnt--;
          end
        end
        if (stray_rdv) begin
          avm.avm_readdatavalid = 1'b1;
          stray_rdv             = 1'b0;
        end
        if (hold > 0) begin
          chk("read_held", {31'd0, avm.avm_read}, 32'd1);
          chk("addr_held", {31'd0, avm.avm_address}, {31'd0, hold_addr});
        end
        if (avm.avm_read) begin
          if (hold == 0) hold_addr = avm.avm_address;
          if (hold < cfg_wait[hold_addr]) begin
            avm.avm_waitrequest = 1'b1;
            hold++;
          end else begin
            avm.avm_waitrequest = 1'b0;
            hold      = 0;
            resp_pend = 1;
            resp_cnt  = cfg_lat[hold_addr];
            resp_addr = hold_addr;
          end
        end else begin
          avm.avm_waitrequest = 1'b0;
          hold = 0;
        end
      end
    end
  end

  function automatic vec_t mkv(input int unsigned wi, li, input bit ri, input logic [31:0] di,
                               input int unsigned wt, lt, input bit rt, input logic [31:0] dt,
                               input int unsigned edges, input bit p, iok, tok, tmo,
                               input logic [31:0] iv, tv);
    vec_t v;
    v.wait_id = wi; v.lat_id = li; v.resp_id = ri; v.data_id = di;
    v.wait_ts = wt; v.lat_ts = lt; v.resp_ts = rt; v.data_ts = dt;
    v.edges = edges; v.pass = p; v.id_ok = iok; v.ts_ok = tok; v.tmo = tmo;
    v.id_val = iv; v.ts_val = tv;
    return v;
  endfunction

  // Reference: each read is a request phase of wait+1 cycles then a response phase of lat
  // cycles; any phase that would exceed T cycles ends the check with a timeout after T.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    int unsigned t;
    int unsigned w [2];
    int unsigned l [2];
    bit          rs [2];
    logic [31:0] d [2];
    logic [31:0] e [2];
    bit          ok [2];
    logic [31:0] val [2];
    bit          tmo;
    r = v; t = 0; tmo = 0;
    w = '{v.wait_id, v.wait_ts}; l = '{v.lat_id, v.lat_ts};
    rs = '{v.resp_id, v.resp_ts}; d = '{v.data_id, v.data_ts}; e = '{EXP_ID, EXP_TS};
    ok = '{0, 0}; val = '{32'd0, 32'd0};
    for (int k = 0; k < 2; k++) begin
      if (!tmo) begin
        if (w[k] + 1 > T) begin
          t += T; tmo = 1;
        end else begin
          t += w[k] + 1;
          if (!rs[k] || l[k] > T) begin
            t += T; tmo = 1;
          end else begin
            t += l[k]; val[k] = d[k]; ok[k] = (d[k] == e[k]);
          end
        end
      end
    end
    r.edges = t; r.tmo = tmo; r.id_ok = ok[0]; r.ts_ok = ok[1];
    r.id_val = val[0]; r.ts_val = val[1];
    r.pass = ok[0] && ok[1] && !tmo;
    return r;
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, ":flags"}, {26'd0, busy, done, pass, id_ok, ts_ok, timeout}, 32'd0);
    chk({name, ":bus"}, {30'd0, avm.avm_read, avm.avm_address}, 32'd0);
    chk({name, ":id_value"}, id_value, 32'd0);
    chk({name, ":ts_value"}, ts_value, 32'd0);
  endtask

  // start_at / reset_at: negedge index (after the start-sampling edge) for extra actions.
  task automatic run_vec(input vec_t v, input string name, input int start_at, input int reset_at);
    int n;
    cfg_wait = '{v.wait_id, v.wait_ts}; cfg_lat  = '{v.lat_id, v.lat_ts};
    cfg_resp = '{v.resp_id, v.resp_ts}; cfg_data = '{v.data_id, v.data_ts};
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({name, ":busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({name, ":cleared"}, {28'd0, id_ok, ts_ok, timeout, done}, 32'd0);
    chk({name, ":values_cleared"}, id_value | ts_value, 32'd0);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clock);
      n++;
      start = (n == start_at);
      if (n == reset_at) begin
        start   = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        chk_all_zero({name, ":after_reset"});
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
    chk({name, ":edges_to_done"}, n, v.edges);
    chk({name, ":pass"}, {31'd0, pass}, {31'd0, v.pass});
    chk({name, ":id_ok/ts_ok/timeout"}, {29'd0, id_ok, ts_ok, timeout},
        {29'd0, v.id_ok, v.ts_ok, v.tmo});
    chk({name, ":id_value"}, id_value, v.id_val);
    chk({name, ":ts_value"}, ts_value, v.ts_val);
    chk({name, ":idle_bus"}, {30'd0, avm.avm_read, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    reset_n = 1'b0;
    start   = 1'b0;
    cfg_wait = '{0, 0}; cfg_lat = '{1, 1}; cfg_resp = '{1, 1}; cfg_data = '{EXP_ID, EXP_TS};

    //            wi li ri di          wt lt rt dt              edg p  iok tok tmo idv          tsv
    tbl.push_back(mkv(0, 1, 1, EXP_ID, 0, 1, 1, EXP_TS,         4,  1, 1,  1,  0,  EXP_ID,      EXP_TS));
    tbl.push_back(mkv(3, 1, 1, EXP_ID, 3, 1, 1, EXP_TS,         10, 1, 1,  1,  0,  EXP_ID,      EXP_TS));
    tbl.push_back(mkv(0, 1, 1, EXP_ID, 0, 1, 1, 32'd1591407028, 4,  0, 1,  0,  0,  EXP_ID,      32'd1591407028));
    tbl.push_back(mkv(0, 1, 0, EXP_ID, 0, 1, 1, EXP_TS,         9,  0, 0,  0,  1,  32'd0,       32'd0));
    tbl.push_back(mkv(0, 1, 1, 32'hDEADBEEF, 0, 1, 1, EXP_TS,   4,  0, 0,  1,  0,  32'hDEADBEEF, EXP_TS));
    tbl.push_back(mkv(0, 1, 1, EXP_ID, 0, 8, 1, EXP_TS,         11, 1, 1,  1,  0,  EXP_ID,      EXP_TS));
    tbl.push_back(mkv(0, 1, 1, EXP_ID, 0, 9, 1, EXP_TS,         11, 0, 1,  0,  1,  EXP_ID,      32'd0));
    tbl.push_back(mkv(7, 1, 1, EXP_ID, 0, 1, 1, EXP_TS,         11, 1, 1,  1,  0,  EXP_ID,      EXP_TS));
    tbl.push_back(mkv(0, 1, 1, EXP_ID, 0, 1, 0, EXP_TS,         11, 0, 1,  0,  1,  EXP_ID,      32'd0));

    repeat (3) @(negedge clock);
    chk_all_zero("reset_state");
    reset_n = 1'b1;

    // Stray readdatavalid in IDLE must not start or capture anything.
    stray_rdv = 1'b1;
    repeat (3) @(negedge clock);
    chk_all_zero("stray_rdv_idle");

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i), -1, -1);

    // start pulsed while waiting for the ID response is ignored.
    v = mkv(0, 4, 1, EXP_ID, 0, 1, 1, EXP_TS, 7, 1, 1, 1, 0, EXP_ID, EXP_TS);
    run_vec(v, "start_in_wait_id", 2, -1);

    // Reset while waiting for the timestamp, then a clean check.
    v = mkv(0, 1, 1, EXP_ID, 0, 6, 1, EXP_TS, 0, 0, 0, 0, 0, 0, 0);
    run_vec(v, "reset_in_wait_ts", -1, 4);
    v = mkv(0, 1, 1, EXP_ID, 0, 1, 1, EXP_TS, 4, 1, 1, 1, 0, EXP_ID, EXP_TS);
    run_vec(v, "after_reset_clean", -1, -1);

    for (int i = 0; i < 40; i++) begin
      v.wait_id = $urandom_range(0, 4);
      v.wait_ts = $urandom_range(0, 4);
      v.lat_id  = $urandom_range(1, 10);
      v.lat_ts  = $urandom_range(1, 10);
      v.resp_id = ($urandom_range(0, 7) != 0);
      v.resp_ts = ($urandom_range(0, 7) != 0);
      v.data_id = ($urandom_range(0, 1) != 0) ? EXP_ID : 32'($urandom);
      v.data_ts = ($urandom_range(0, 1) != 0) ? EXP_TS : 32'($urandom);
      run_vec(predict(v), $sformatf("rand%0d", i), -1, -1);
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mysystem_sysid_checker.md
Name: mysystem_sysid_checker

Overview:
- Avalon-MM read master that interrogates the system-ID slave at boot or on request.
- Reads word 0 (system ID) and then word 1 (build timestamp), and compares each against the expected build values.
- Reports pass/fail, which field mismatched, and whether the slave failed to respond.
- Sits beside the boot/reset controller; its pass flag gates software start and drives a status LED.

Parameters:
- EXPECTED_ID, 0, expected value of word 0.
- EXPECTED_TIMESTAMP, 1591407027, expected value of word 1.
- TIMEOUT_CYCLES, 255, maximum cycles spent in any one request or response phase; legal range 1..65535.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- start  in  1  one-cycle request to run a check
- avm_address  out  1  word address: 0 = ID, 1 = timestamp
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid
- busy  out  1  check in progress
- done  out  1  level; high from the end of a check until the next start
- pass  out  1  id_ok AND ts_ok AND NOT timeout; valid while done
- id_ok  out  1  word 0 == EXPECTED_ID
- ts_ok  out  1  word 1 == EXPECTED_TIMESTAMP
- timeout  out  1  slave did not respond within TIMEOUT_CYCLES
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1

Behaviour:
- Reset: single clock, synchronous, active-low reset. Sampled at the clock edge, it forces state IDLE and drives every output to 0, including avm_read and both captured values. Reset mid-transaction abandons the transaction; avm_read is low in the cycle after the reset edge.
- States and transitions:
  - IDLE: start -> RD_ID.
  - RD_ID: avm_read=1, avm_address=0. If avm_waitrequest=0 at the edge -> WAIT_ID.
  - WAIT_ID: avm_readdatavalid=1 -> capture id_value, set id_ok -> RD_TS.
  - RD_TS: avm_read=1, avm_address=1. If avm_waitrequest=0 -> WAIT_TS.
  - WAIT_TS: avm_readdatavalid=1 -> capture ts_value, set ts_ok -> DONE.
  - DONE: done=1. start -> clear all flags and captured values, then -> RD_ID.
- Handshake:
  - avm_read and avm_address are registered and held stable while avm_waitrequest=1.
  - avm_read drops in the cycle after acceptance.
  - Only one read is outstanding at a time.
  - avm_readdatavalid is honoured only in WAIT_ID and WAIT_TS and is ignored in every other state. Earliest honoured response is one cycle after acceptance.
- busy = 1 in RD_ID, WAIT_ID, RD_TS and WAIT_TS.
- start while busy is ignored.
- Latency: with waitrequest=0 and 1-cycle read latency, done rises 4 edges after the edge that samples start.
- Timeout:
  - Counter width is 16 bits; it clears on every state change.
  - It increments each cycle in RD_* and WAIT_* states.
  - When count reaches TIMEOUT_CYCLES and no handshake occurs on that edge: timeout=1, avm_read=0, -> DONE. The flags of any field not yet read remain 0.
  - If a handshake and the counter limit coincide on the same edge, the handshake wins.
- Comparison is a full 32-bit equality check with no masking.

Decomposition:
- Shared package mysystem_sysid_pkg holds:
  - the state enum (IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE);
  - word-address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1;
  - the timeout counter width constant (16).
- No sub-module; the FSM, counter and capture registers live in one module.

Test Plan:
- Zero-wait slave returning 0 then 1591407027 -> done after 4 edges, pass=1, id_ok=1, ts_ok=1, timeout=0.
- Slave holds waitrequest for 3 cycles on each read -> address and read held stable throughout; done after 10 edges; pass=1.
- Slave returns timestamp 1591407028 -> ts_ok=0, id_ok=1, pass=0, ts_value=1591407028.
- Slave never asserts readdatavalid, with TIMEOUT_CYCLES=8 -> timeout=1 after 8 wait cycles; avm_read low; id_ok=0; pass=0.
- start pulsed during WAIT_ID and a stray readdatavalid in IDLE -> both ignored; a single check completes normally.
- reset_n low during WAIT_TS, then high -> all outputs 0; the next start runs a clean check that passes.
